scroll_feeder: RTL and testbench



---
 rtl/scroll_pkg.sv | 14 +
 rtl/font5x7_rom.sv | 56 +++++
 rtl/scroll_feeder.sv | 102 ++++++++++
 tb/tb_scroll_feeder.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scroll_pkg.sv
// Shared state type, character codes and font geometry for the scrolling message feeder.
package scroll_pkg;
    localparam int FONT_COLS = 5;
    localparam int FONT_ROWS = 7;

    localparam logic [5:0] CH_SPACE = 6'd0;
    localparam logic [5:0] CH_A     = 6'd1;
    localparam logic [5:0] CH_0     = 6'd27;

    typedef enum logic [1:0] {IDLE, CHAR, GAP, FLUSH} scroll_state_t;

    // glyph[0] is the leftmost column; bit 0 of each column is the top row
    typedef logic [FONT_COLS-1:0][FONT_ROWS-1:0] glyph_t;
endpackage

// File: rtl/font5x7_rom.sv
// Combinational 5x7 font: character code -> five 7-bit columns (bit 0 = top row).
// Codes outside space, A..Z and 0..9 return an all-blank glyph.
module font5x7_rom
    import scroll_pkg::*;
(
    input  logic [5:0] code,
    output glyph_t     glyph
);
    function automatic glyph_t cols(input logic [6:0] c0, c1, c2, c3, c4);
        return {c4, c3, c2, c1, c0};
    endfunction

    always_comb begin
        glyph = '0;
        case (code)
            CH_SPACE:     glyph = '0;
            CH_A+6'd0:    glyph = cols(7'h7E, 7'h09, 7'h09, 7'h09, 7'h7E);
            CH_A+6'd1:    glyph = cols(7'h7F, 7'h49, 7'h49, 7'h49, 7'h36);
            CH_A+6'd2:    glyph = cols(7'h3E, 7'h41, 7'h41, 7'h41, 7'h22);
            CH_A+6'd3:    glyph = cols(7'h7F, 7'h41, 7'h41, 7'h22, 7'h1C);
            CH_A+6'd4:    glyph = cols(7'h7F, 7'h49, 7'h49, 7'h49, 7'h41);
            CH_A+6'd5:    glyph = cols(7'h7F, 7'h09, 7'h09, 7'h09, 7'h01);
            CH_A+6'd6:    glyph = cols(7'h3E, 7'h41, 7'h49, 7'h49, 7'h7A);
            CH_A+6'd7:    glyph = cols(7'h7F, 7'h08, 7'h08, 7'h08, 7'h7F);
            CH_A+6'd8:    glyph = cols(7'h00, 7'h41, 7'h7F, 7'h41, 7'h00);
            CH_A+6'd9:    glyph = cols(7'h20, 7'h40, 7'h41, 7'h3F, 7'h01);
            CH_A+6'd10:   glyph = cols(7'h7F, 7'h08, 7'h14, 7'h22, 7'h41);
            CH_A+6'd11:   glyph = cols(7'h7F, 7'h40, 7'h40, 7'h40, 7'h40);
            CH_A+6'd12:   glyph = cols(7'h7F, 7'h02, 7'h1C, 7'h02, 7'h7F);
            CH_A+6'd13:   glyph = cols(7'h7F, 7'h04, 7'h08, 7'h10, 7'h7F);
            CH_A+6'd14:   glyph = cols(7'h3E, 7'h41, 7'h41, 7'h41, 7'h3E);
            CH_A+6'd15:   glyph = cols(7'h7F, 7'h09, 7'h09, 7'h09, 7'h06);
            CH_A+6'd16:   glyph = cols(7'h3E, 7'h41, 7'h51, 7'h21, 7'h5E);
            CH_A+6'd17:   glyph = cols(7'h7F, 7'h09, 7'h19, 7'h29, 7'h46);
            CH_A+6'd18:   glyph = cols(7'h46, 7'h49, 7'h49, 7'h49, 7'h31);
            CH_A+6'd19:   glyph = cols(7'h01, 7'h01, 7'h7F, 7'h01, 7'h01);
            CH_A+6'd20:   glyph = cols(7'h3F, 7'h40, 7'h40, 7'h40, 7'h3F);
            CH_A+6'd21:   glyph = cols(7'h1F, 7'h20, 7'h40, 7'h20, 7'h1F);
            CH_A+6'd22:   glyph = cols(7'h3F, 7'h40, 7'h38, 7'h40, 7'h3F);
            CH_A+6'd23:   glyph = cols(7'h63, 7'h14, 7'h08, 7'h14, 7'h63);
            CH_A+6'd24:   glyph = cols(7'h07, 7'h08, 7'h70, 7'h08, 7'h07);
            CH_A+6'd25:   glyph = cols(7'h61, 7'h51, 7'h49, 7'h45, 7'h43);
            CH_0+6'd0:    glyph = cols(7'h3E, 7'h51, 7'h49, 7'h45, 7'h3E);
            CH_0+6'd1:    glyph = cols(7'h00, 7'h42, 7'h7F, 7'h40, 7'h00);
            CH_0+6'd2:    glyph = cols(7'h42, 7'h61, 7'h51, 7'h49, 7'h46);
            CH_0+6'd3:    glyph = cols(7'h21, 7'h41, 7'h45, 7'h4B, 7'h31);
            CH_0+6'd4:    glyph = cols(7'h18, 7'h14, 7'h12, 7'h7F, 7'h10);
            CH_0+6'd5:    glyph = cols(7'h27, 7'h45, 7'h45, 7'h45, 7'h39);
            CH_0+6'd6:    glyph = cols(7'h3C, 7'h4A, 7'h49, 7'h49, 7'h30);
            CH_0+6'd7:    glyph = cols(7'h01, 7'h71, 7'h09, 7'h05, 7'h03);
            CH_0+6'd8:    glyph = cols(7'h36, 7'h49, 7'h49, 7'h49, 7'h36);
            CH_0+6'd9:    glyph = cols(7'h06, 7'h49, 7'h49, 7'h29, 7'h1E);
            default:      glyph = '0;
        endcase
    end
endmodule

// File: rtl/scroll_feeder.sv
// Emits one font column per clk_6hz edge (registered, one edge after the selecting state); enable=0 freezes
// position and emits blanks. Define SCROLL_FLUSH_EN to append 5 blank columns before each wrap.
module scroll_feeder
    import scroll_pkg::*;
#(
    parameter int MSG_LEN  = 4,
    parameter int GAP_COLS = 1
) (
    input  logic       clk_6hz,
    input  logic       rst,
    input  logic       enable,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [5:0] wr_char,
    output logic [6:0] row_data,
    output logic [3:0] char_idx,
    output logic       frame_done
);
    localparam logic [3:0] LAST_IDX = 4'(MSG_LEN - 1);
    localparam logic [2:0] LAST_COL = 3'(FONT_COLS - 1);
    localparam logic [2:0] LAST_GAP = 3'(GAP_COLS - 1);

    scroll_state_t state;
    logic [2:0]    col;
    logic [5:0]    msg [16];
    glyph_t        glyph;
    logic          char_end;
    logic          last_char;

    font5x7_rom u_font (
        .code  (msg[char_idx]),
        .glyph (glyph)
    );

    // High on the final column (glyph or gap) belonging to the current slot
    always_comb begin
        char_end = 1'b0;
        if (state == CHAR)
            char_end = (col == LAST_COL) && (GAP_COLS == 0);
        else if (state == GAP)
            char_end = (col == LAST_GAP);
    end

    assign last_char = (char_idx == LAST_IDX);

    always_ff @(posedge clk_6hz or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            col        <= '0;
            char_idx   <= '0;
            row_data   <= '0;
            frame_done <= 1'b0;
            for (int i = 0; i < 16; i++) msg[i] <= '0;
        end else begin
            for (int i = 0; i < MSG_LEN; i++)
                if (wr_en && wr_addr == 4'(i)) msg[i] <= wr_char;

            row_data   <= '0;
            frame_done <= 1'b0;
            if (enable) begin
                case (state)
                    IDLE: state <= CHAR;
                    CHAR: begin
                        row_data <= glyph[col];
                        if (col == LAST_COL) begin
                            col <= '0;
                            if (GAP_COLS > 0) state <= GAP;
                        end else begin
                            col <= col + 3'd1;
                        end
                    end
                    GAP: col <= (col == LAST_GAP) ? 3'd0 : col + 3'd1;
`ifdef SCROLL_FLUSH_EN
                    FLUSH: begin
                        if (col == LAST_COL) begin
                            col        <= '0;
                            state      <= CHAR;
                            frame_done <= 1'b1;
                        end else begin
                            col <= col + 3'd1;
                        end
                    end
`endif
                    default: state <= IDLE;
                endcase

                // Slot boundary overrides the per-state transition above
                if (char_end) begin
                    state    <= CHAR;
                    char_idx <= last_char ? 4'd0 : char_idx + 4'd1;
                    if (last_char) begin
`ifdef SCROLL_FLUSH_EN
                        state <= FLUSH;
`else
                        frame_done <= 1'b1;
`endif
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_scroll_feeder.sv
// Bench for scroll_feeder: three parameterisations share one stimulus stream; a column-position model
// pushes expected outputs per edge into a queue that each scenario pops and compares.
module tb_scroll_feeder;
    localparam int NI = 3;
`ifdef SCROLL_FLUSH_EN
    localparam int FLUSH_COLS = 5;
`else
    localparam int FLUSH_COLS = 0;
`endif

    typedef struct packed {
        logic [6:0] row;
        logic       done;
        logic [3:0] idx;
    } exp_t;

    logic       clk_6hz = 1'b0;
    logic       rst     = 1'b1;
    logic       enable  = 1'b0;
    logic       wr_en   = 1'b0;
    logic [3:0] wr_addr = '0;
    logic [5:0] wr_char = '0;

    logic [6:0] row_a, row_b, row_c;
    logic [3:0] idx_a, idx_b, idx_c;
    logic       done_a, done_b, done_c;
    exp_t       obs [NI];

    logic [5:0] mm [NI][16];
    int         pos [NI];
    bit         started [NI];
    exp_t       sb [$];
    int         checks = 0;
    int         errors = 0;

    scroll_feeder #(.MSG_LEN(4), .GAP_COLS(1)) dut_a (
        .clk_6hz(clk_6hz), .rst(rst), .enable(enable), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_char(wr_char), .row_data(row_a), .char_idx(idx_a), .frame_done(done_a));
    scroll_feeder #(.MSG_LEN(2), .GAP_COLS(1)) dut_b (
        .clk_6hz(clk_6hz), .rst(rst), .enable(enable), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_char(wr_char), .row_data(row_b), .char_idx(idx_b), .frame_done(done_b));
    scroll_feeder #(.MSG_LEN(3), .GAP_COLS(0)) dut_c (
        .clk_6hz(clk_6hz), .rst(rst), .enable(enable), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_char(wr_char), .row_data(row_c), .char_idx(idx_c), .frame_done(done_c));

    assign obs[0] = {row_a, done_a, idx_a};
    assign obs[1] = {row_b, done_b, idx_b};
    assign obs[2] = {row_c, done_c, idx_c};

    always #5 clk_6hz = ~clk_6hz;

    function automatic int len_of(input int i);
        case (i)
            0:       return 4;
            1:       return 2;
            default: return 3;
        endcase
    endfunction

    function automatic int gap_of(input int i);
        return (i == 2) ? 0 : 1;
    endfunction

    // Only the glyphs quoted for this block; every other code used here is blank
    function automatic logic [6:0] ref_glyph(input logic [5:0] code, input int c);
        logic [34:0] g;
        case (code)
            6'd1:    g = {7'h7E, 7'h09, 7'h09, 7'h09, 7'h7E};
            6'd9:    g = {7'h00, 7'h41, 7'h7F, 7'h41, 7'h00};
            default: g = '0;
        endcase
        return g[34 - 7*c -: 7];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NI; i++) begin
            pos[i] = 0;
            started[i] = 1'b0;
            for (int j = 0; j < 16; j++) mm[i][j] = '0;
        end
    endtask

    // Drive one edge's inputs, queue the expected outputs of that edge, land at the next negedge
    task automatic cycle(input logic en, input logic we, input logic [3:0] wa, input logic [5:0] wc);
        enable = en; wr_en = we; wr_addr = wa; wr_char = wc;
        for (int i = 0; i < NI; i++) begin
            exp_t e;
            int per, flen, slot, c;
            per  = 5 + gap_of(i);
            flen = len_of(i) * per + FLUSH_COLS;
            e.row = '0;
            e.done = 1'b0;
            if (en) begin
                if (!started[i]) begin
                    started[i] = 1'b1;
                end else begin
                    slot = pos[i] / per;
                    c    = pos[i] % per;
                    if (slot < len_of(i) && c < 5) e.row = ref_glyph(mm[i][slot], c);
                    e.done = (pos[i] == flen - 1);
                    pos[i] = (pos[i] + 1) % flen;
                end
            end
            e.idx = (pos[i] < len_of(i) * per) ? 4'(pos[i] / per) : 4'd0;
            sb.push_back(e);
            if (we && int'(wa) < len_of(i)) mm[i][wa] = wc;
        end
        @(posedge clk_6hz);
        @(negedge clk_6hz);
        wr_en = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1; enable = 1'b0; wr_en = 1'b0;
        @(negedge clk_6hz);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        @(negedge clk_6hz);
        @(negedge clk_6hz);
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (obs[i] !== '0) begin
                errors++;
                $display("FAIL reset inst%0d: got %h, want 0", i, obs[i]);
            end
        end
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_blank_frame();
        for (int k = 0; k < 32; k++) begin
            cycle(1'b1, 1'b0, 4'd0, 6'd0);
            for (int i = 0; i < NI; i++) begin
                exp_t e;
                e = sb.pop_front();
                checks++;
                if (obs[i] !== e) begin
                    errors++;
                    $display("FAIL blank inst%0d step%0d: got row=%h done=%b idx=%0d, want row=%h done=%b idx=%0d",
                             i, k, obs[i].row, obs[i].done, obs[i].idx, e.row, e.done, e.idx);
                end
            end
        end
    endtask

    task automatic test_glyph_i();
        apply_reset();
        for (int k = 0; k < 10; k++) begin
            if (k == 0) cycle(1'b0, 1'b1, 4'd0, 6'd9);
            else        cycle(1'b1, 1'b0, 4'd0, 6'd0);
            for (int i = 0; i < NI; i++) begin
                exp_t e;
                e = sb.pop_front();
                checks++;
                if (obs[i] !== e) begin
                    errors++;
                    $display("FAIL glyph_i inst%0d step%0d: got row=%h done=%b idx=%0d, want row=%h done=%b idx=%0d",
                             i, k, obs[i].row, obs[i].done, obs[i].idx, e.row, e.done, e.idx);
                end
            end
        end
    endtask

    task automatic test_frame_wrap();
        logic [3:0] wa [4];
        logic [5:0] wc [4];
        wa = '{4'd0, 4'd1, 4'd2, 4'd3};
        wc = '{6'd1, 6'd1, 6'd40, 6'd1};
        apply_reset();
        for (int k = 0; k < 44; k++) begin
            if (k < 4) cycle(1'b0, 1'b1, wa[k], wc[k]);
            else       cycle(1'b1, 1'b0, 4'd0, 6'd0);
            for (int i = 0; i < NI; i++) begin
                exp_t e;
                e = sb.pop_front();
                checks++;
                if (obs[i] !== e) begin
                    errors++;
                    $display("FAIL wrap inst%0d step%0d: got row=%h done=%b idx=%0d, want row=%h done=%b idx=%0d",
                             i, k, obs[i].row, obs[i].done, obs[i].idx, e.row, e.done, e.idx);
                end
            end
        end
    endtask

    task automatic test_pause();
        logic en_tbl [11];
        en_tbl = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        apply_reset();
        for (int k = 0; k < 11; k++) begin
            cycle(en_tbl[k], k == 0, 4'd0, 6'd1);
            for (int i = 0; i < NI; i++) begin
                exp_t e;
                e = sb.pop_front();
                checks++;
                if (obs[i] !== e) begin
                    errors++;
                    $display("FAIL pause inst%0d step%0d: got row=%h done=%b idx=%0d, want row=%h done=%b idx=%0d",
                             i, k, obs[i].row, obs[i].done, obs[i].idx, e.row, e.done, e.idx);
                end
            end
        end
    endtask

    task automatic test_overwrite();
        apply_reset();
        for (int k = 0; k < 8; k++) begin
            if (k == 0)      cycle(1'b0, 1'b1, 4'd0, 6'd9);
            else if (k == 3) cycle(1'b1, 1'b1, 4'd0, 6'd1);
            else             cycle(1'b1, 1'b0, 4'd0, 6'd0);
            for (int i = 0; i < NI; i++) begin
                exp_t e;
                e = sb.pop_front();
                checks++;
                if (obs[i] !== e) begin
                    errors++;
                    $display("FAIL overwrite inst%0d step%0d: got row=%h done=%b idx=%0d, want row=%h done=%b idx=%0d",
                             i, k, obs[i].row, obs[i].done, obs[i].idx, e.row, e.done, e.idx);
                end
            end
            if (k == 4) begin
                checks++;
                if (row_a !== 7'h09) begin
                    errors++;
                    $display("FAIL overwrite_col2: got %h, want 09", row_a);
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        apply_reset();
        for (int k = 0; k < 22; k++) begin
            if (k == 0)      cycle(1'b0, 1'b1, 4'd0, 6'd9);
            else if (k == 1) cycle(1'b0, 1'b1, 4'd1, 6'd1);
            else if (k < 9)  cycle(1'b1, 1'b0, 4'd0, 6'd0);
            else if (k == 9) begin
                #2;
                rst = 1'b1; enable = 1'b0; wr_en = 1'b1; wr_addr = 4'd0; wr_char = 6'd9;
                #1;
                for (int i = 0; i < NI; i++) begin
                    checks++;
                    if (obs[i] !== '0) begin
                        errors++;
                        $display("FAIL async_reset inst%0d: got %h, want 0", i, obs[i]);
                    end
                end
                @(posedge clk_6hz);
                @(negedge clk_6hz);
                rst = 1'b0; wr_en = 1'b0;
                model_clear();
                cycle(1'b0, 1'b1, 4'd1, 6'd1);
            end else begin
                cycle(1'b1, 1'b0, 4'd0, 6'd0);
            end
            for (int i = 0; i < NI; i++) begin
                exp_t e;
                e = sb.pop_front();
                checks++;
                if (obs[i] !== e) begin
                    errors++;
                    $display("FAIL rst_mid inst%0d step%0d: got row=%h done=%b idx=%0d, want row=%h done=%b idx=%0d",
                             i, k, obs[i].row, obs[i].done, obs[i].idx, e.row, e.done, e.idx);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_blank_frame();
        test_glyph_i();
        test_frame_wrap();
        test_pause();
        test_overwrite();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
